// File: rtl/fast2slow_hs_cdc.sv
// Fast-to-slow multi-bit CDC using a two-phase toggle req/ack handshake.
// Exactly one word is in flight; words offered while busy are dropped and counted.
module fast2slow_hs_cdc #(
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             fst_clk,
    input  logic             slw_clk,
    input  logic             rst,
    input  logic [DW-1:0]    data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [DW-1:0]    data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             fst_state_o,
    output logic             slw_state_o
);

    // Handshakes: fast side transfers on fst_clk when valid_i && ready_o;
    // slow side transfers on slw_clk when valid_o && ready_i.

    typedef enum logic {F_IDLE = 1'b0, F_BUSY = 1'b1} fst_state_e;
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slw_state_e;

    // ---------------- fast domain ----------------
    fst_state_e             fst_state_q, fst_state_d;
    logic [DW-1:0]          data_fst_q, data_fst_d;
    logic                   req_tgl_q, req_tgl_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;

    // ---------------- slow domain ----------------
    slw_state_e             slw_state_q, slw_state_d;
    logic [DW-1:0]          data_o_q, data_o_d;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_tgl_q, ack_tgl_d;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_sync;

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];
    assign req_sync = req_sync_q[SYNC_STAGES-1];

    always_ff @(posedge fst_clk or posedge rst) begin
        if (rst) begin
            fst_state_q <= F_IDLE;
            data_fst_q  <= '0;
            req_tgl_q   <= 1'b0;
            drop_cnt_q  <= '0;
            ack_sync_q  <= '0;
        end else begin
            fst_state_q <= fst_state_d;
            data_fst_q  <= data_fst_d;
            req_tgl_q   <= req_tgl_d;
            drop_cnt_q  <= drop_cnt_d;
            ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
        end
    end

    always_comb begin
        fst_state_d = fst_state_q;
        data_fst_d  = data_fst_q;
        req_tgl_d   = req_tgl_q;
        drop_cnt_d  = drop_cnt_q;
        case (fst_state_q)
            F_IDLE: begin
                if (valid_i) begin
                    data_fst_d  = data_i;
                    req_tgl_d   = ~req_tgl_q;
                    fst_state_d = F_BUSY;
                end
            end
            F_BUSY: begin
                if (ack_sync == req_tgl_q) begin
                    fst_state_d = F_IDLE;
                end
                // ready_o is still low on this edge, so an offer here is a drop.
                if (valid_i && (drop_cnt_q != {CNT_W{1'b1}})) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end
            end
            default: fst_state_d = F_IDLE;
        endcase
    end

    assign ready_o     = (fst_state_q == F_IDLE);
    assign drop_cnt_o  = drop_cnt_q;
    assign fst_state_o = fst_state_q;

    always_ff @(posedge slw_clk or posedge rst) begin
        if (rst) begin
            slw_state_q <= S_EMPTY;
            data_o_q    <= '0;
            req_seen_q  <= 1'b0;
            ack_tgl_q   <= 1'b0;
            req_sync_q  <= '0;
        end else begin
            slw_state_q <= slw_state_d;
            data_o_q    <= data_o_d;
            req_seen_q  <= req_seen_d;
            ack_tgl_q   <= ack_tgl_d;
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
        end
    end

    // data_fst_q is held stable by the fast FSM until ack returns, so it is
    // safe to sample here once the synchronised request has changed.
    always_comb begin
        slw_state_d = slw_state_q;
        data_o_d    = data_o_q;
        req_seen_d  = req_seen_q;
        ack_tgl_d   = ack_tgl_q;
        case (slw_state_q)
            S_EMPTY: begin
                if (req_sync != req_seen_q) begin
                    data_o_d    = data_fst_q;
                    req_seen_d  = req_sync;
                    slw_state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (ready_i) begin
                    ack_tgl_d   = req_seen_q;
                    slw_state_d = S_EMPTY;
                end
            end
            default: slw_state_d = S_EMPTY;
        endcase
    end

    assign valid_o     = (slw_state_q == S_FULL);
    assign data_o      = data_o_q;
    assign slw_state_o = slw_state_q;

endmodule

// File: tb/tb_fast2slow_hs_cdc.sv
// Directed bench for fast2slow_hs_cdc: latency, backpressure, drops, saturation,
// reset mid-flight, plus a randomised scoreboard run on a SYNC_STAGES=3 instance.
module tb_fast2slow_hs_cdc;

    // ---------------- clock / reset ----------------
    logic fst_clk = 1'b0;
    logic slw_clk = 1'b0;
    logic s2_clk  = 1'b0;
    logic rst     = 1'b1;
    logic rst2    = 1'b1;
    int   s2_half;

    always #5  fst_clk = ~fst_clk;   // 100 MHz
    always #20 slw_clk = ~slw_clk;   // 25 MHz
    initial begin
        s2_half = $urandom_range(8, 40);  // fst/slw ratio 1.6 .. 8
        forever #(s2_half) s2_clk = ~s2_clk;
    end

    // ---------------- DUT 1: DW=16, SYNC=2, CNT_W=16 ----------------
    logic [15:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        ready_o, valid_o, fst_st, slw_st;
    logic [15:0] drop_cnt, data_o;

    fast2slow_hs_cdc #(.DW(16), .SYNC_STAGES(2), .CNT_W(16)) u_dut (
        .fst_clk(fst_clk), .slw_clk(slw_clk), .rst(rst),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .drop_cnt_o(drop_cnt), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .fst_state_o(fst_st), .slw_state_o(slw_st)
    );

    // ---------------- DUT 2: DW=16, SYNC=3, CNT_W=3 ----------------
    logic [15:0] data2_i = '0;
    logic        valid2_i = 1'b0;
    logic        ready2_i = 1'b0;
    logic        ready2_o, valid2_o, fst2_st, slw2_st;
    logic [2:0]  drop2;
    logic [15:0] data2_o;

    fast2slow_hs_cdc #(.DW(16), .SYNC_STAGES(3), .CNT_W(3)) u_dut2 (
        .fst_clk(fst_clk), .slw_clk(s2_clk), .rst(rst2),
        .data_i(data2_i), .valid_i(valid2_i), .ready_o(ready2_o),
        .drop_cnt_o(drop2), .data_o(data2_o), .valid_o(valid2_o),
        .ready_i(ready2_i), .fst_state_o(fst2_st), .slw_state_o(slw2_st)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp2_q[$];
    bit          mon_en  = 1'b0;
    bit          mon2_en = 1'b0;
    bit          rnd2_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Slow inputs only change #1 after a slow posedge, so a handshake seen at
    // the negedge is exactly the one consumed on the following posedge.
    always @(negedge slw_clk) begin
        if (mon_en && valid_o && ready_i) begin
            if (exp_q.size() == 0) check("mon1_unexpected_word", 32'(exp_q.size()), 32'd1);
            else                   check("mon1_data", 32'(data_o), 32'(exp_q.pop_front()));
        end
    end

    always @(negedge s2_clk) begin
        if (mon2_en && valid2_o) begin
            check("mon2_no_x", 32'($isunknown(data2_o)), 32'd0);
            if (ready2_i) begin
                if (exp2_q.size() == 0) check("mon2_unexpected_word", 32'(exp2_q.size()), 32'd1);
                else                    check("mon2_data", 32'(data2_o), 32'(exp2_q.pop_front()));
            end
        end
    end

    always @(posedge s2_clk) begin
        if (rnd2_en) begin
            #1;
            ready2_i = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] d);
        @(negedge fst_clk);
        data_i  = d;
        valid_i = 1'b1;
        @(posedge fst_clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int k = 0; k < max_cyc && !valid_o; k++) begin
            @(posedge slw_clk);
            #1;
        end
        check("wait_valid", 32'(valid_o), 32'd1);
    endtask

    task automatic wait_ready(input int max_cyc);
        for (int k = 0; k < max_cyc && !ready_o; k++) begin
            @(posedge fst_clk);
            #1;
        end
        check("wait_ready", 32'(ready_o), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int fe;
        int acc;

        #100;
        @(negedge slw_clk);
        rst = 1'b0;
        #1;
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);

        // Single word, ready_i=1: valid_o on slow edge 3, for one slow cycle.
        ready_i = 1'b1;
        send(16'hA5C3);
        check("t1_ready_low", 32'(ready_o), 32'd0);
        fe = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge slw_clk);
            #1;
            if (valid_o) begin
                fe = k;
                break;
            end
        end
        check("t1_fwd_latency", 32'(fe), 32'd3);
        check("t1_data_o", 32'(data_o), 32'hA5C3);
        @(posedge slw_clk);
        #1;
        check("t1_one_cycle", 32'(valid_o), 32'd0);
        fe = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge fst_clk);
            #1;
            if (ready_o) begin
                fe = k;
                break;
            end
        end
        check("t1_ret_latency", 32'(fe), 32'd3);

        // Backpressure: consumer stalls 10 slow cycles.
        @(posedge slw_clk);
        #1;
        ready_i = 1'b0;
        send(16'h5A5A);
        wait_valid(10);
        for (int k = 0; k < 10; k++) begin
            @(posedge slw_clk);
            #1;
            check("t2_hold_valid", 32'(valid_o), 32'd1);
            check("t2_hold_data", 32'(data_o), 32'h5A5A);
            check("t2_hold_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(posedge slw_clk);
        #1;
        check("t2_consumed", 32'(valid_o), 32'd0);
        wait_ready(20);

        // Drops: valid_i high 200 cycles with incrementing data.
        mon_en = 1'b1;
        acc    = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge fst_clk);
            valid_i = 1'b1;
            data_i  = 16'h0100 + 16'(i);
            if (ready_o) begin
                exp_q.push_back(data_i);
                acc++;
            end
        end
        @(negedge fst_clk);
        valid_i = 1'b0;
        for (int k = 0; k < 400 && (exp_q.size() != 0 || !ready_o); k++) @(negedge fst_clk);
        check("t3_all_consumed", 32'(exp_q.size()), 32'd0);
        check("t3_drop_cnt", 32'(drop_cnt), 32'(200 - acc));
        mon_en = 1'b0;

        // Reset while the slow side is FULL.
        ready_i = 1'b0;
        send(16'h7777);
        wait_valid(10);
        @(negedge fst_clk);
        valid_i = 1'b1;
        repeat (3) @(negedge fst_clk);
        valid_i = 1'b0;
        @(posedge slw_clk);
        #7;
        rst = 1'b1;
        #1;
        check("t5_valid_cleared", 32'(valid_o), 32'd0);
        check("t5_data_cleared", 32'(data_o), 32'd0);
        check("t5_ready_set", 32'(ready_o), 32'd1);
        check("t5_drop_cleared", 32'(drop_cnt), 32'd0);
        #100;
        @(negedge slw_clk);
        rst = 1'b0;
        ready_i = 1'b1;
        send(16'h1234);
        wait_valid(10);
        check("t5_data_after", 32'(data_o), 32'h1234);
        check("t5_no_drop", 32'(drop_cnt), 32'd0);
        wait_ready(40);

        // Saturation on the CNT_W=3 instance: consumer stalled, 1 accept then drops.
        repeat (4) @(posedge s2_clk);
        @(negedge s2_clk);
        rst2 = 1'b0;
        mon2_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge fst_clk);
            valid2_i = 1'b1;
            data2_i  = 16'h0C00 + 16'(i);
            if (ready2_o) exp2_q.push_back(data2_i);
            if (i == 5) check("t4_partial", 32'(drop2), 32'd4);
        end
        @(negedge fst_clk);
        check("t4_saturated", 32'(drop2), 32'd7);
        repeat (5) @(negedge fst_clk);
        valid2_i = 1'b0;
        @(negedge fst_clk);
        check("t4_holds", 32'(drop2), 32'd7);
        @(posedge s2_clk);
        #1;
        ready2_i = 1'b1;
        for (int k = 0; k < 400 && (exp2_q.size() != 0 || !ready2_o); k++) @(negedge fst_clk);
        check("t4_drained", 32'(exp2_q.size()), 32'd0);

        // Randomised traffic on the SYNC_STAGES=3 instance.
        rnd2_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge fst_clk);
            valid2_i = ($urandom_range(0, 3) != 0);
            data2_i  = 16'($urandom);
            if (valid2_i && ready2_o) exp2_q.push_back(data2_i);
        end
        @(negedge fst_clk);
        valid2_i = 1'b0;
        for (int k = 0; k < 4000 && (exp2_q.size() != 0 || !ready2_o); k++) @(negedge fst_clk);
        check("t6_scoreboard_empty", 32'(exp2_q.size()), 32'd0);
        rnd2_en = 1'b0;
        mon2_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fast2slow_hs_cdc.md
# fast2slow_hs_cdc

Parametrised fast-to-slow clock-domain crossing for multi-bit words with full valid/ready flow control on both sides. It uses a two-phase (toggle) request/acknowledge handshake with a configurable synchroniser depth. Slow-side backpressure propagates back to the fast-side producer, and words offered while the block is busy are dropped and counted. It sits between fast-clock DSP/capture logic and slow-clock control/readout logic.

## Interface
- DW, 16, data word width (≥1)
- SYNC_STAGES, 2, flops per synchroniser chain (≥2)
- CNT_W, 16, drop-counter width (≥1)

- fst_clk  in  1  fast clock
- slw_clk  in  1  slow clock
- rst  in  1  reset, asynchronous, active-high; resets both domains
- data_i  in  DW  fast-side write data
- valid_i  in  1  fast-side write request
- ready_o  out  1  fast-side acceptance; a word is accepted on a fst_clk edge with valid_i && ready_o
- drop_cnt_o  out  CNT_W  fast-domain count of words offered while ready_o=0; saturating
- data_o  out  DW  slow-side read data
- valid_o  out  1  slow-side data valid
- ready_i  in  1  slow-side consumer ready; a word is consumed on a slw_clk edge with valid_o && ready_i

## Operation
- Fast FSM has two states, IDLE and BUSY. ready_o is registered and equals (state==IDLE).
  - IDLE, valid_i=1: register data_i into data_fst, toggle req_tgl, go to BUSY.
  - BUSY: hold data_fst and req_tgl. Return to IDLE when ack_sync (last synchroniser stage) == req_tgl.
  - valid_i=1 while BUSY: the word is dropped and drop_cnt_o increments by 1. It saturates at 2^CNT_W−1 and never wraps.
- req_tgl crosses into slw_clk through a SYNC_STAGES-deep chain giving req_sync. ack_tgl crosses into fst_clk the same way giving ack_sync. data_fst is never synchronised; it is sampled only after req_sync changes, and it is stable for that whole window.
- Slow FSM has two states, EMPTY and FULL. valid_o equals (state==FULL) and is registered.
  - EMPTY, req_sync != req_seen: load data_o <= data_fst, set req_seen <= req_sync, go to FULL.
  - FULL, ready_i=1: go to EMPTY and set ack_tgl <= req_seen.
  - FULL, ready_i=0: hold data_o and valid_o unchanged, for any number of cycles.
- Because ack is issued only at consumption, at most one word is in flight. A new request cannot arrive while FULL.
- There is no combinational path from valid_i to ready_o, or from ready_i to valid_o.

## Timing
- Reset values:
  - ready_o=1, drop_cnt_o=0, valid_o=0, data_o=0.
  - req_tgl, ack_tgl, req_seen and all synchroniser flops are 0.
  - Both FSMs reset to IDLE/EMPTY.
- Forward latency: valid_o rises on slw_clk edge SYNC_STAGES+1, counting from the first slw edge after req_tgl toggles.
- Return latency: ready_o rises on fst_clk edge SYNC_STAGES+1, counting from the first fst edge after ack_tgl toggles.
- ready_o falls on the accepting fst edge. The word offered on that same edge is accepted and is not counted as a drop.
- Throughput: one word per full round trip, which includes slow-side dwell time while ready_i is low.
- A slow-side handshake on edge m clears valid_o at m. The next word can assert valid_o no earlier than edge m+1.
- Reset mid-operation: all state clears immediately. Any in-flight or held word is discarded and is not counted as a drop. Hold rst for at least 2 slw_clk periods.
- The toggle encoding handles req/ack parity wrap naturally; no counters are involved in the handshake.

## Test plan
- Single word, DW=16, SYNC_STAGES=2, fst 100 MHz, slw 25 MHz, ready_i=1:
  - valid_i pulse with 0xA5C3 -> ready_o=0 on the next fst edge.
  - valid_o=1 with data_o=0xA5C3 on slw edge 3, for exactly one slw cycle.
  - ready_o returns to 1 three fst edges after ack_tgl toggles.
- Backpressure: ready_i=0 for 10 slw cycles after valid_o rises.
  - data_o and valid_o stay stable and ready_o stays 0 throughout.
  - Releasing ready_i completes the handshake and ready_o returns.
- Drops: valid_i held high for 200 fst cycles with an incrementing data_i, ready_i=1.
  - Every slow output word is one that was accepted.
  - drop_cnt_o = 200 − (number of accepted words).
  - No word appears twice.
- Saturation: CNT_W=3, force 12 drops -> drop_cnt_o=7 and holds there.
- Reset mid-flight:
  - Assert rst while the slow side is FULL -> valid_o=0, data_o=0, ready_o=1, drop_cnt_o=0 immediately.
  - After release, the next word 0x1234 crosses correctly.
- Randomised: SYNC_STAGES=3, random clock ratio (fst/slw between 1.5 and 8), random valid_i/ready_i.
  - A scoreboard checks that accepted words equal consumed words, in order.
  - No X appears on data_o while valid_o=1.
